snake_head_stepper: RTL and testbench
=====================================

SNAKE_HEAD_STEPPER -- requirements
Module: snake_head_stepper

Interface
REQ-001 SHALL have parameter GRID_W, default 32, grid width in cells.
REQ-002 SHALL have parameter GRID_H, default 24, grid height in cells.
REQ-003 SHALL have parameter X_W, default 5, head_x width; Y_W, default 5, head_y width.
REQ-004 SHALL have parameter TICK_CYCLES, default 12500000, clock cycles per move step; legal range is >= 2.
REQ-005 SHALL have parameters START_X, default 16, and START_Y, default 12, giving the spawn cell.
REQ-006 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports U, D, L, R, noMove, input, 1 each, the direction-request outputs of the snake move-state FSM.
REQ-009 SHALL have port start, input, 1, single-cycle start/restart request.
REQ-010 SHALL have port head_x, output, X_W, the current head column.
REQ-011 SHALL have port head_y, output, Y_W, the current head row; row 0 is the top row.
REQ-012 SHALL have port dir, output, 2, the committed heading: 00=up, 01=down, 10=left, 11=right.
REQ-013 SHALL have port step, output, 1, one-cycle pulse on each successful head move.
REQ-014 SHALL have port running, output, 1, high in state RUN.
REQ-015 SHALL have port game_over, output, 1, high in state DEAD.

Function
REQ-016 SHALL implement states IDLE, RUN, DEAD; all outputs are registered.
REQ-017 IDLE: hold head at (START_X, START_Y) and dir=11; on start, go to RUN, clear the tick counter, and set pending_dir=11.
REQ-018 RUN: the tick counter counts 0..TICK_CYCLES-1 and wraps; the terminal count is the move event.
REQ-019 RUN, every cycle: a request is valid only when exactly one of U/D/L/R is high and noMove is low.
REQ-020 A valid request that is not the opposite of the committed dir SHALL load pending_dir.
REQ-021 A request opposite to dir, a request with multiple bits high, or noMove SHALL leave pending_dir unchanged.
REQ-022 Reversal checks SHALL compare against the committed dir, not pending_dir. Example: with dir=R, the sequence U then L within one tick leaves pending_dir=U.
REQ-023 Move event: dir<=pending_dir; the next cell is up y-1, down y+1, left x-1, right x+1, computed with the new dir.
REQ-024 Move event where the next cell is out of bounds SHALL go to DEAD, leave head_x, head_y, and dir at their pre-event values, and hold step low. Out of bounds means y=0 going up, y=GRID_H-1 going down, x=0 going left, or x=GRID_W-1 going right.
REQ-025 Move event with an in-bounds next cell SHALL update head_x and head_y to that cell and assert step for exactly that one cycle.
REQ-026 There SHALL be no wrap-around; arithmetic never underflows or overflows X_W or Y_W.
REQ-027 start SHALL be ignored in RUN.
REQ-028 DEAD: hold head_x, head_y, and dir frozen.
REQ-029 DEAD + start: reload head to (START_X, START_Y), set dir=11 and pending_dir=11, clear the counter, and go directly to RUN.
REQ-030 A valid request in the same cycle as a move event SHALL be applied to pending_dir after the commit, so it is tested against the new dir.
REQ-031 Latency: the first move event SHALL occur TICK_CYCLES cycles after the start cycle.

Reset
REQ-032 reset_n low SHALL immediately force state IDLE, head=(START_X, START_Y), dir=11, pending_dir=11, counter=0, step=0, running=0, game_over=0.
REQ-033 Reset asserted mid-RUN or mid-DEAD SHALL abort any pending move; the block leaves IDLE only on start after reset_n releases.

Verification
REQ-034 TICK_CYCLES=4, reset, pulse start, no requests -> step every 4 cycles; head_x 16->17->18; head_y=12; dir=11.
REQ-035 In RUN with dir=R, assert L for the whole tick -> dir stays 11, head_x increments; then U held -> at the next event dir=00, head_y decrements by 1.
REQ-036 dir=R, U and then L within one tick -> the commit gives dir=00; L is then held across the next tick -> dir=10 at the following event.
REQ-037 Drive the head to x=GRID_W-1 heading R -> at the next event game_over=1, running=0, head_x=GRID_W-1, step=0; further ticks cause no change.
REQ-038 In DEAD, pulse start -> the next cycle gives running=1, head=(16,12), dir=11; the first step occurs TICK_CYCLES cycles later.
REQ-039 Assert reset_n low asynchronously between clock edges mid-RUN -> outputs reach reset values before the next edge; start is ignored while reset_n is low.

Source files
------------

// File: rtl/snake_head_stepper.sv
// Snake head position stepper: moves the head one cell per tick in the committed heading.
// Turn requests are filtered against reversal; an out-of-bounds move ends the game until start.
module snake_head_stepper #(
  parameter int GRID_W      = 32,
  parameter int GRID_H      = 24,
  parameter int X_W         = 5,
  parameter int Y_W         = 5,
  parameter int TICK_CYCLES = 12500000,
  parameter int START_X     = 16,
  parameter int START_Y     = 12
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           U,
  input  logic           D,
  input  logic           L,
  input  logic           R,
  input  logic           noMove,
  input  logic           start,
  output logic [X_W-1:0] head_x,
  output logic [Y_W-1:0] head_y,
  output logic [1:0]     dir,
  output logic           step,
  output logic           running,
  output logic           game_over
);

  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);
  localparam logic [X_W-1:0]   X_MAX    = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0]   Y_MAX    = Y_W'(GRID_H - 1);
  localparam logic [X_W-1:0]   X_START  = X_W'(START_X);
  localparam logic [Y_W-1:0]   Y_START  = Y_W'(START_Y);

  localparam logic [1:0] DIR_U = 2'b00;
  localparam logic [1:0] DIR_D = 2'b01;
  localparam logic [1:0] DIR_L = 2'b10;
  localparam logic [1:0] DIR_R = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DEAD = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       pend_q, pend_d;
  logic [1:0]       dir_q, dir_d;
  logic [X_W-1:0]   head_x_q, head_x_d;
  logic [Y_W-1:0]   head_y_q, head_y_d;
  logic             step_q, step_d;
  logic             running_q, running_d;
  logic             game_over_q, game_over_d;

  logic             req_vld;
  logic [1:0]       req_dir;
  logic             move_evt;
  logic [1:0]       commit_dir;
  logic             oob;

  // Decode the direction request: exactly one line high and noMove low.
  always_comb begin
    req_vld = 1'b0;
    req_dir = DIR_R;
    case ({U, D, L, R})
      4'b1000: begin req_vld = 1'b1; req_dir = DIR_U; end
      4'b0100: begin req_vld = 1'b1; req_dir = DIR_D; end
      4'b0010: begin req_vld = 1'b1; req_dir = DIR_L; end
      4'b0001: begin req_vld = 1'b1; req_dir = DIR_R; end
      default: begin req_vld = 1'b0; req_dir = DIR_R; end
    endcase
    if (noMove) req_vld = 1'b0;
  end

  always_comb begin
    move_evt   = (state_q == ST_RUN) && (cnt_q == CNT_LAST);
    commit_dir = move_evt ? pend_q : dir_q;
    case (commit_dir)
      DIR_U:   oob = (head_y_q == '0);
      DIR_D:   oob = (head_y_q == Y_MAX);
      DIR_L:   oob = (head_x_q == '0);
      default: oob = (head_x_q == X_MAX);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    dir_d    = dir_q;
    head_x_d = head_x_q;
    head_y_d = head_y_q;
    step_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        head_x_d = X_START;
        head_y_d = Y_START;
        dir_d    = DIR_R;
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          pend_d  = DIR_R;
        end
      end
      ST_RUN: begin
        cnt_d = move_evt ? '0 : cnt_q + CNT_W'(1);
        if (move_evt) begin
          if (oob) begin
            state_d = ST_DEAD;
          end else begin
            dir_d  = commit_dir;
            step_d = 1'b1;
            case (commit_dir)
              DIR_U:   head_y_d = head_y_q - Y_W'(1);
              DIR_D:   head_y_d = head_y_q + Y_W'(1);
              DIR_L:   head_x_d = head_x_q - X_W'(1);
              default: head_x_d = head_x_q + X_W'(1);
            endcase
          end
        end
        // Same-cycle requests are judged against the heading just committed.
        if (req_vld && (req_dir != (commit_dir ^ 2'b01))) pend_d = req_dir;
      end
      ST_DEAD: begin
        if (start) begin
          state_d  = ST_RUN;
          cnt_d    = '0;
          pend_d   = DIR_R;
          dir_d    = DIR_R;
          head_x_d = X_START;
          head_y_d = Y_START;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    running_d   = (state_d == ST_RUN);
    game_over_d = (state_d == ST_DEAD);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pend_q      <= DIR_R;
      dir_q       <= DIR_R;
      head_x_q    <= X_START;
      head_y_q    <= Y_START;
      step_q      <= 1'b0;
      running_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      dir_q       <= dir_d;
      head_x_q    <= head_x_d;
      head_y_q    <= head_y_d;
      step_q      <= step_d;
      running_q   <= running_d;
      game_over_q <= game_over_d;
    end
  end

  assign head_x    = head_x_q;
  assign head_y    = head_y_q;
  assign dir       = dir_q;
  assign step      = step_q;
  assign running   = running_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_snake_head_stepper.sv
// Bench for snake_head_stepper: directed scenarios plus random requests against a grid-walk model.
module tb_snake_head_stepper;

  localparam int T  = 4;
  localparam int GW = 32;
  localparam int GH = 24;
  localparam int SX = 16;
  localparam int SY = 12;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       U = 1'b0, D = 1'b0, L = 1'b0, R = 1'b0, noMove = 1'b0, start = 1'b0;
  logic [4:0] head_x;
  logic [4:0] head_y;
  logic [1:0] dir;
  logic       step, running, game_over;

  int n_checks = 0;
  int n_fail   = 0;

  snake_head_stepper #(
    .GRID_W(GW), .GRID_H(GH), .X_W(5), .Y_W(5),
    .TICK_CYCLES(T), .START_X(SX), .START_Y(SY)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .U(U), .D(D), .L(L), .R(R), .noMove(noMove), .start(start),
    .head_x(head_x), .head_y(head_y), .dir(dir),
    .step(step), .running(running), .game_over(game_over)
  );

  always #5 clock = ~clock;

  wire [14:0] act_vec = {head_x, head_y, dir, step, running, game_over};

  // Reference: 0=idle 1=run 2=dead; headings 0=up 1=down 2=left 3=right.
  int m_mode, m_x, m_y, m_dir, m_pend, m_phase, m_step;
  int dx[4]  = '{0, 0, -1, 1};
  int dy[4]  = '{-1, 1, 0, 0};
  int opp[4] = '{1, 0, 3, 2};

  function automatic logic [14:0] exp_vec();
    logic [4:0] ex, ey;
    logic [1:0] ed;
    ex = m_x[4:0];
    ey = m_y[4:0];
    ed = m_dir[1:0];
    return {ex, ey, ed, m_step != 0, m_mode == 1, m_mode == 2};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_x = SX; m_y = SY; m_dir = 3; m_pend = 3; m_phase = 0; m_step = 0;
  endtask

  task automatic model_edge(input logic [3:0] udlr, input logic nm, input logic st);
    int nd, nx, ny, req, nbits;
    m_step = 0;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (m_mode == 0) begin
      if (st) begin m_mode = 1; m_phase = 0; m_pend = 3; end
    end else if (m_mode == 2) begin
      if (st) begin
        m_mode = 1; m_phase = 0; m_pend = 3; m_dir = 3; m_x = SX; m_y = SY;
      end
    end else begin
      if (m_phase == T - 1) begin
        nd = m_pend;
        nx = m_x + dx[nd];
        ny = m_y + dy[nd];
        if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
          m_mode = 2;
        end else begin
          m_x = nx; m_y = ny; m_dir = nd; m_step = 1;
        end
      end
      m_phase = (m_phase + 1) % T;
      nbits = udlr[3] + udlr[2] + udlr[1] + udlr[0];
      req = udlr[3] ? 0 : udlr[2] ? 1 : udlr[1] ? 2 : 3;
      if (m_mode == 1 && nbits == 1 && !nm && req != opp[m_dir]) m_pend = req;
    end
  endtask

  // Drive inputs after the previous edge, advance the model at the edge, settle 1ns.
  task automatic cycle(input logic [3:0] udlr, input logic nm, input logic st);
    {U, D, L, R} = udlr;
    noMove = nm;
    start  = st;
    @(posedge clock);
    model_edge(udlr, nm, st);
    #1;
  endtask

  task automatic fresh();
    reset_n = 1'b0;
    #1;
    model_reset();
    cycle(4'b0000, 1'b0, 1'b0);
    reset_n = 1'b1;
    cycle(4'b0000, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (act_vec !== {5'd16, 5'd12, 2'b11, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", act_vec, {5'd16, 5'd12, 2'b11, 3'b000});
    end
    cycle(4'b0000, 1'b0, 1'b1);
    n_checks++;
    if (act_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_hold_start_ignored: got %h expected %h", act_vec, exp_vec());
    end
    reset_n = 1'b1;
    cycle(4'b0000, 1'b0, 1'b0);
    n_checks++;
    if (running !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_no_start: running got %0b expected 0", running);
    end
  endtask

  task automatic test_straight();
    fresh();
    for (int i = 1; i <= 12; i++) begin
      cycle(4'b0000, 1'b0, 1'b0);
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL straight cyc%0d: got %h expected %h", i, act_vec, exp_vec());
      end
      if (i == 4) begin
        n_checks++;
        if ({head_x, step} !== {5'd17, 1'b1}) begin
          n_fail++;
          $display("FAIL straight_first_step: got x=%0d step=%0b expected x=17 step=1", head_x, step);
        end
      end
      if (i == 8) begin
        n_checks++;
        if ({head_x, head_y, dir} !== {5'd18, 5'd12, 2'b11}) begin
          n_fail++;
          $display("FAIL straight_second_step: got x=%0d y=%0d dir=%0d expected 18 12 3", head_x, head_y, dir);
        end
      end
    end
  endtask

  task automatic test_reversal();
    fresh();
    for (int i = 1; i <= 8; i++) begin
      cycle((i <= 4) ? 4'b0010 : 4'b1000, 1'b0, 1'b0);
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL reversal cyc%0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
    n_checks++;
    if ({head_x, head_y, dir} !== {5'd17, 5'd11, 2'b00}) begin
      n_fail++;
      $display("FAIL reversal_turn_up: got x=%0d y=%0d dir=%0d expected 17 11 0", head_x, head_y, dir);
    end
  endtask

  task automatic test_pending_vs_committed();
    logic [3:0] seq[8];
    seq = '{4'b1000, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
    fresh();
    for (int i = 0; i < 8; i++) begin
      cycle(seq[i], 1'b0, 1'b0);
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL pending cyc%0d: got %h expected %h", i, act_vec, exp_vec());
      end
      if (i == 3) begin
        n_checks++;
        if ({head_x, head_y, dir} !== {5'd16, 5'd11, 2'b00}) begin
          n_fail++;
          $display("FAIL pending_commit_up: got x=%0d y=%0d dir=%0d expected 16 11 0", head_x, head_y, dir);
        end
      end
    end
    n_checks++;
    if ({head_x, head_y, dir} !== {5'd15, 5'd11, 2'b10}) begin
      n_fail++;
      $display("FAIL pending_commit_left: got x=%0d y=%0d dir=%0d expected 15 11 2", head_x, head_y, dir);
    end
  endtask

  task automatic test_wall();
    fresh();
    for (int i = 1; i <= 16 * T; i++) begin
      cycle(4'b0000, 1'b0, 1'b0);
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL wall cyc%0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
    n_checks++;
    if ({game_over, running, head_x, step, dir} !== {1'b1, 1'b0, 5'd31, 1'b0, 2'b11}) begin
      n_fail++;
      $display("FAIL wall_death: got go=%0b run=%0b x=%0d step=%0b dir=%0d expected 1 0 31 0 3",
               game_over, running, head_x, step, dir);
    end
    for (int i = 0; i < 3 * T; i++) begin
      cycle(4'b1000, 1'b0, 1'b0);
      n_checks++;
      if (act_vec !== {5'd31, 5'd12, 2'b11, 1'b0, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL dead_frozen cyc%0d: got %h expected %h", i, act_vec, {5'd31, 5'd12, 2'b11, 3'b001});
      end
    end
  endtask

  task automatic test_restart();
    cycle(4'b0000, 1'b0, 1'b1);
    n_checks++;
    if (act_vec !== {5'd16, 5'd12, 2'b11, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL restart_reload: got %h expected %h", act_vec, {5'd16, 5'd12, 2'b11, 3'b010});
    end
    for (int i = 1; i <= T; i++) begin
      cycle(4'b0000, 1'b0, 1'b0);
      n_checks++;
      if (step !== (i == T)) begin
        n_fail++;
        $display("FAIL restart_latency cyc%0d: step got %0b expected %0b", i, step, i == T);
      end
    end
  endtask

  task automatic test_async_reset();
    fresh();
    for (int i = 0; i < 6; i++) cycle(4'b0100, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (act_vec !== {5'd16, 5'd12, 2'b11, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset_immediate: got %h expected %h", act_vec, {5'd16, 5'd12, 2'b11, 3'b000});
    end
    for (int i = 0; i < 2; i++) begin
      cycle(4'b0000, 1'b0, 1'b1);
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL async_reset_start_ignored cyc%0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
    reset_n = 1'b1;
    for (int i = 0; i < 2 * T; i++) begin
      cycle(4'b0000, 1'b0, 1'b0);
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL async_reset_stays_idle cyc%0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] udlr;
    logic       nm, st;
    fresh();
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       udlr = 4'b0000;
        1:       udlr = 4'($urandom_range(0, 15));
        default: udlr = 4'b0001 << $urandom_range(0, 3);
      endcase
      nm = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 24) == 0);
      cycle(udlr, nm, st);
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc%0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_straight();
    test_reversal();
    test_pending_vs_committed();
    test_wall();
    test_restart();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
